// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU mantissa sequencer: sizing, one-hot state
// bit positions, operand format codes and cyc0_type operand-class codes.
package fpu_seq_pkg;

  localparam int unsigned NOPS_MAX = 2;  // maximum operands per operation
  localparam int unsigned WCNT_W   = 2;  // operand-word counter width
  localparam int unsigned ST_W     = 8;  // one-hot state vector width

  // One-hot bit positions of the sequencer state.
  localparam int unsigned S0 = 0;  // IDLE
  localparam int unsigned S1 = 1;  // LOAD
  localparam int unsigned S2 = 2;  // EXEC
  localparam int unsigned S3 = 3;  // OUT_SGL
  localparam int unsigned S4 = 4;  // OUT_DLSW
  localparam int unsigned S5 = 5;  // OUT_DMSW
  localparam int unsigned S6 = 6;  // OUT_LLO
  localparam int unsigned S7 = 7;  // OUT_HI

  // Operand format codes.
  localparam logic [1:0] FMT_SGL = 2'd0;
  localparam logic [1:0] FMT_DBL = 2'd1;
  localparam logic [1:0] FMT_INT = 2'd2;
  localparam logic [1:0] FMT_LNG = 2'd3;

  // Operand class presented on cyc0_type.
  localparam logic [2:0] CT_DBL0 = 3'd0;
  localparam logic [2:0] CT_SGL  = 3'd1;
  localparam logic [2:0] CT_LNG  = 3'd2;
  localparam logic [2:0] CT_DBL  = 3'd3;
  localparam logic [2:0] CT_INT  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE     = ST_W'(1 << S0),
    ST_LOAD     = ST_W'(1 << S1),
    ST_EXEC     = ST_W'(1 << S2),
    ST_OUT_SGL  = ST_W'(1 << S3),
    ST_OUT_DLSW = ST_W'(1 << S4),
    ST_OUT_DMSW = ST_W'(1 << S5),
    ST_OUT_LLO  = ST_W'(1 << S6),
    ST_OUT_HI   = ST_W'(1 << S7)
  } state_t;

endpackage

// File: rtl/fpu_ld_cnt.sv
// Operand-word counter for the LOAD phase. Counts accepted words, flags the
// last word of the operation and generates the per-word load strobes and the
// operand class for the A1/B1 pre-selects.
//   clk, reset_l  : clock, async active-low reset
//   clr           : clear the counter (new operation or abort)
//   load          : sequencer is in LOAD
//   ld_valid      : operand word on the load bus this cycle
//   fmt, two      : latched operand format / two-operand flag
//   cyc0_rdy      : first word of an operand accepted this cycle
//   cyc1_rdy      : second word of a double/long operand accepted this cycle
//   cyc0_type     : operand class while a strobe is high, else 0
//   last          : final word of the operation accepted this cycle
module fpu_ld_cnt
  import fpu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  input  logic       clr,
  input  logic       load,
  input  logic       ld_valid,
  input  logic [1:0] fmt,
  input  logic       two,
  output logic       cyc0_rdy,
  output logic       cyc1_rdy,
  output logic [2:0] cyc0_type,
  output logic       last
);

  // One extra bit so NOPS_MAX * 2 words is representable before the -1.
  localparam int unsigned TOT_W = WCNT_W + 1;

  logic [WCNT_W-1:0] cnt;
  logic [TOT_W-1:0]  wpo;
  logic [TOT_W-1:0]  ops;
  logic [TOT_W-1:0]  total;
  logic              wide;
  logic              word_idx;
  logic              opnd_idx;
  logic              take;

  // Word position decode and strobe generation.
  always_comb begin
    wide      = (fmt == FMT_DBL) || (fmt == FMT_LNG);
    wpo       = wide ? TOT_W'(2) : TOT_W'(1);
    ops       = two ? TOT_W'(NOPS_MAX) : TOT_W'(1);
    total     = wpo * ops;
    // Wide formats: bit 0 is the word within the operand, bit 1 the operand.
    word_idx  = wide & cnt[0];
    opnd_idx  = wide ? cnt[1] : cnt[0];
    take      = load & ld_valid;
    last      = take & (cnt == WCNT_W'(total - TOT_W'(1)));
    cyc0_rdy  = take & ~word_idx;
    cyc1_rdy  = take & wide & word_idx;
    cyc0_type = '0;
    if (cyc0_rdy || cyc1_rdy) begin
      unique case (fmt)
        FMT_SGL: cyc0_type = CT_SGL;
        FMT_INT: cyc0_type = CT_INT;
        FMT_LNG: cyc0_type = CT_LNG;
        default: cyc0_type = (two && !opnd_idx) ? CT_DBL0 : CT_DBL;
      endcase
    end
  end

  // Word counter; clr wins over an accepted word.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (clr || last) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= cnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/fpu_mant_seq.sv
// FPU mantissa datapath sequencer. Accepts an operation, steps operand words
// into the A/B mantissa registers, waits for the arithmetic core and then
// walks the result-output states, exposing the one-hot state to the
// mantissa decode logic.
//   clk, reset_l         : clock, async active-low reset
//   op_start/op_fmt/op_two : operation request (sampled in IDLE only)
//   ld_valid             : operand word present on the load bus
//   compute_done         : arithmetic core finished
//   out_ack              : consumer accepts the current result word
//   kill                 : abort, highest priority
//   busy                 : not in IDLE
//   cyc0_rdy/cyc1_rdy    : operand word load strobes (same cycle as ld_valid)
//   cyc0_type            : operand class for the A1/B1 pre-selects
//   fpu_state            : one-hot state s0..s7
//   out_valid            : result word valid (s3..s7)
module fpu_mant_seq
  import fpu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_l,
  input  logic            op_start,
  input  logic [1:0]      op_fmt,
  input  logic            op_two,
  input  logic            ld_valid,
  input  logic            compute_done,
  input  logic            out_ack,
  input  logic            kill,
  output logic            busy,
  output logic            cyc0_rdy,
  output logic            cyc1_rdy,
  output logic [2:0]      cyc0_type,
  output logic [ST_W-1:0] fpu_state,
  output logic            out_valid
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] fmt_q;
  logic       two_q;
  logic       start;
  logic       last;

  // A start that coincides with kill is dropped.
  assign start     = (state == ST_IDLE) && op_start && !kill;
  assign fpu_state = state;

  fpu_ld_cnt u_ld_cnt (
    .clk       (clk),
    .reset_l   (reset_l),
    .clr       (kill | start),
    .load      (state == ST_LOAD),
    .ld_valid  (ld_valid),
    .fmt       (fmt_q),
    .two       (two_q),
    .cyc0_rdy  (cyc0_rdy),
    .cyc1_rdy  (cyc1_rdy),
    .cyc0_type (cyc0_type),
    .last      (last)
  );

  // State register, operation latch and registered status outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      fmt_q     <= '0;
      two_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= ~state_nxt[S0];
      out_valid <= |state_nxt[S7:S3];
      if (start) begin
        fmt_q <= op_fmt;
        two_q <= op_two;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:     if (op_start) state_nxt = ST_LOAD;
        ST_LOAD:     if (last) state_nxt = ST_EXEC;
        ST_EXEC: begin
          if (compute_done) begin
            unique case (fmt_q)
              FMT_SGL: state_nxt = ST_OUT_SGL;
              FMT_DBL: state_nxt = ST_OUT_DLSW;
              FMT_LNG: state_nxt = ST_OUT_LLO;
              default: state_nxt = ST_OUT_HI;
            endcase
          end
        end
        ST_OUT_SGL:  if (out_ack) state_nxt = ST_IDLE;
        ST_OUT_DLSW: if (out_ack) state_nxt = ST_OUT_DMSW;
        ST_OUT_DMSW: if (out_ack) state_nxt = ST_IDLE;
        ST_OUT_LLO:  if (out_ack) state_nxt = ST_OUT_HI;
        ST_OUT_HI:   if (out_ack) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mant_seq.sv
// Scoreboard bench for fpu_mant_seq: expected load strobes and result words
// are queued when stimulus is issued; a negedge monitor pops and compares.
module tb_fpu_mant_seq;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       op_start = 1'b0;
  logic [1:0] op_fmt = 2'd0;
  logic       op_two = 1'b0;
  logic       ld_valid = 1'b0;
  logic       compute_done = 1'b0;
  logic       out_ack = 1'b0;
  logic       kill = 1'b0;
  logic       busy;
  logic       cyc0_rdy;
  logic       cyc1_rdy;
  logic [2:0] cyc0_type;
  logic [7:0] fpu_state;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  logic [4:0] ld_q[$];   // {cyc0_rdy, cyc1_rdy, cyc0_type}
  logic [7:0] out_q[$];  // fpu_state of each accepted result word

  fpu_mant_seq dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .op_start     (op_start),
    .op_fmt       (op_fmt),
    .op_two       (op_two),
    .ld_valid     (ld_valid),
    .compute_done (compute_done),
    .out_ack      (out_ack),
    .kill         (kill),
    .busy         (busy),
    .cyc0_rdy     (cyc0_rdy),
    .cyc1_rdy     (cyc1_rdy),
    .cyc0_type    (cyc0_type),
    .fpu_state    (fpu_state),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ld(input logic r0, input logic r1, input logic [2:0] t);
    ld_q.push_back({r0, r1, t});
  endtask

  task automatic start_op(input logic [1:0] f, input logic t);
    op_start = 1'b1;
    op_fmt   = f;
    op_two   = t;
    tick();
    op_start = 1'b0;
    chk("start_to_s1", 32'(fpu_state), 32'h02);
  endtask

  task automatic load_words(input int n);
    ld_valid = 1'b1;
    repeat (n) tick();
    ld_valid = 1'b0;
  endtask

  task automatic done_to(input logic [7:0] exp);
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("exec_to_out", 32'(fpu_state), 32'(exp));
    chk("out_valid", 32'(out_valid), 32'd1);
  endtask

  // Monitor: compare DUT-presented loads and accepted result words.
  always @(negedge clk) begin
    if (reset_l) begin
      if (cyc0_rdy || cyc1_rdy) begin
        if (ld_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL load_unexpected: got %b%b/%0d expected none", cyc0_rdy, cyc1_rdy, cyc0_type);
        end else begin
          chk("load_word", 32'({cyc0_rdy, cyc1_rdy, cyc0_type}), 32'(ld_q.pop_front()));
        end
      end
      if (out_valid && out_ack && !kill) begin
        if (out_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got state %0h expected none", fpu_state);
        end else begin
          chk("out_word", 32'(fpu_state), 32'(out_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #12;
    chk("rst_state", 32'(fpu_state), 32'h01);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_type", 32'({cyc0_rdy, cyc1_rdy, cyc0_type}), 32'd0);
    reset_l = 1'b1;
    tick();

    // Two-operand double: types 0,0,3,3; s2 after the fourth word.
    start_op(2'd1, 1'b1);
    push_ld(1, 0, 3'd0); push_ld(0, 1, 3'd0);
    push_ld(1, 0, 3'd3); push_ld(0, 1, 3'd3);
    load_words(3);
    chk("dbl2_hold_s1", 32'(fpu_state), 32'h02);
    load_words(1);
    chk("dbl2_s2", 32'(fpu_state), 32'h04);
    out_q.push_back(8'h10); out_q.push_back(8'h20);
    done_to(8'h10);
    out_ack = 1'b1;
    tick();
    chk("dbl_s5", 32'(fpu_state), 32'h20);
    tick();
    out_ack = 1'b0;
    chk("dbl_idle", 32'(fpu_state), 32'h01);
    chk("dbl_busy", 32'(busy), 32'd0);

    // Single one operand, gapped load, delayed compute_done and ack.
    start_op(2'd0, 1'b0);
    push_ld(1, 0, 3'd1);
    load_words(1);
    tick(); tick();
    repeat (3) tick();
    chk("sgl_exec_hold", 32'(fpu_state), 32'h04);
    out_q.push_back(8'h08);
    done_to(8'h08);
    repeat (3) tick();
    chk("sgl_ack_hold", 32'(fpu_state), 32'h08);
    chk("sgl_valid_hold", 32'(out_valid), 32'd1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("sgl_idle", 32'(fpu_state), 32'h01);
    chk("sgl_busy", 32'(busy), 32'd0);
    chk("sgl_out_valid", 32'(out_valid), 32'd0);

    // Long one operand: 40 -> 80 -> 01.
    start_op(2'd3, 1'b0);
    push_ld(1, 0, 3'd2); push_ld(0, 1, 3'd2);
    load_words(2);
    chk("lng_s2", 32'(fpu_state), 32'h04);
    out_q.push_back(8'h40); out_q.push_back(8'h80);
    done_to(8'h40);
    out_ack = 1'b1;
    tick();
    chk("lng_hi", 32'(fpu_state), 32'h80);
    tick();
    out_ack = 1'b0;
    chk("lng_idle", 32'(fpu_state), 32'h01);

    // Int two operands: two single-word loads, result in s7 only.
    start_op(2'd2, 1'b1);
    push_ld(1, 0, 3'd4); push_ld(1, 0, 3'd4);
    load_words(2);
    chk("int_s2", 32'(fpu_state), 32'h04);
    out_q.push_back(8'h80);
    done_to(8'h80);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("int_idle", 32'(fpu_state), 32'h01);

    // Kill with ack in s5: abort, no s5 word; next start accepted.
    start_op(2'd1, 1'b0);
    push_ld(1, 0, 3'd3); push_ld(0, 1, 3'd3);
    load_words(2);
    out_q.push_back(8'h10);
    done_to(8'h10);
    out_ack = 1'b1;
    tick();
    chk("kill_pre_s5", 32'(fpu_state), 32'h20);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    out_ack = 1'b0;
    chk("kill_idle", 32'(fpu_state), 32'h01);
    chk("kill_busy", 32'(busy), 32'd0);
    start_op(2'd0, 1'b0);
    push_ld(1, 0, 3'd1);
    load_words(1);
    out_q.push_back(8'h08);
    done_to(8'h08);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("post_kill_idle", 32'(fpu_state), 32'h01);

    // Kill together with op_start in IDLE: start dropped.
    op_start = 1'b1; kill = 1'b1;
    tick();
    op_start = 1'b0; kill = 1'b0;
    chk("kill_start_drop", 32'(fpu_state), 32'h01);
    tick();
    chk("kill_start_stay", 32'(fpu_state), 32'h01);

    // Async reset mid-LOAD after word 1 of a two-operand double.
    start_op(2'd1, 1'b1);
    push_ld(1, 0, 3'd0);
    load_words(1);
    #2 reset_l = 1'b0;
    #1;
    chk("arst_state", 32'(fpu_state), 32'h01);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_strobes", 32'({cyc0_rdy, cyc1_rdy, cyc0_type}), 32'd0);
    reset_l = 1'b1;
    tick();
    start_op(2'd1, 1'b1);
    push_ld(1, 0, 3'd0); push_ld(0, 1, 3'd0);
    push_ld(1, 0, 3'd3); push_ld(0, 1, 3'd3);
    load_words(4);
    chk("arst_reload_s2", 32'(fpu_state), 32'h04);
    out_q.push_back(8'h10); out_q.push_back(8'h20);
    done_to(8'h10);
    out_ack = 1'b1;
    tick(); tick();
    out_ack = 1'b0;
    chk("arst_reload_idle", 32'(fpu_state), 32'h01);

    // op_start held through LOAD/EXEC: ignored, one operation only.
    op_start = 1'b1; op_fmt = 2'd2; op_two = 1'b0;
    tick();
    chk("hold_start_s1", 32'(fpu_state), 32'h02);
    push_ld(1, 0, 3'd4);
    load_words(1);
    repeat (3) tick();
    chk("hold_start_s2", 32'(fpu_state), 32'h04);
    op_start = 1'b0;
    out_q.push_back(8'h80);
    done_to(8'h80);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("hold_start_idle", 32'(fpu_state), 32'h01);
    tick();
    chk("hold_start_no_2nd", 32'(fpu_state), 32'h01);
    chk("hold_start_busy", 32'(busy), 32'd0);

    tick();
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    chk("out_q_drained", 32'(out_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
